// File: rtl/prach_pkg.sv
// Shared PRACH front-end definitions: CP-removal FSM states, sample width
// and the format-0 default occasion lengths.
package prach_pkg;

  typedef enum logic [1:0] {
    CPR_IDLE = 2'd0,
    CPR_CP   = 2'd1,
    CPR_SEQ  = 2'd2
  } cpr_state_e;

  localparam int PRACH_WIDTH = 144;
  localparam int CP_LEN_F0   = 3168;
  localparam int SEQ_LEN_F0  = 24576;

endpackage

// File: rtl/prach_cp_remove.sv
// Drops the cyclic prefix of each PRACH occasion in the unstallable antenna
// stream and forwards the sequence words to the CP-buffer FIFO write port.
module prach_cp_remove
  import prach_pkg::*;
#(
  parameter int WIDTH = PRACH_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_cp_len,
  input  logic [CNT_W-1:0] cfg_seq_len,
  input  logic             s_valid,
  input  logic             s_sop,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             ovf,
  output logic             sop_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  cpr_state_e       state_q, state_d, ph_state_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, ph_cnt_s;
  logic [CNT_W-1:0] cp_last_q, cp_last_d, ph_cp_last_s;
  logic [CNT_W-1:0] seq_last_q, seq_last_d, ph_seq_last_s;
  logic             busy_q, sop_err_q, sop_err_d;
  logic             keep_s, last_s, load_s;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;

  // FSM next state: an s_sop word restarts the occasion and is itself
  // processed as word 0 of the CP (or SEQ when cp_len is 0) phase.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cp_last_d     = cp_last_q;
    seq_last_d    = seq_last_q;
    sop_err_d     = 1'b0;
    keep_s        = 1'b0;
    last_s        = 1'b0;
    ph_state_s    = state_q;
    ph_cnt_s      = cnt_q;
    ph_cp_last_s  = cp_last_q;
    ph_seq_last_s = seq_last_q;
    if (s_valid && s_sop) begin
      sop_err_d     = (state_q != CPR_IDLE);
      ph_cnt_s      = CNT_ZERO;
      ph_cp_last_s  = cfg_cp_len - CNT_ONE;
      ph_seq_last_s = cfg_seq_len - CNT_ONE;
      cp_last_d     = ph_cp_last_s;
      seq_last_d    = ph_seq_last_s;
      if (cfg_seq_len == CNT_ZERO) begin
        ph_state_s = CPR_IDLE;
      end else if (cfg_cp_len == CNT_ZERO) begin
        ph_state_s = CPR_SEQ;
      end else begin
        ph_state_s = CPR_CP;
      end
    end else begin
      ph_state_s = state_q;
    end
    if (s_valid) begin
      case (ph_state_s)
        CPR_CP: begin
          if (ph_cnt_s == ph_cp_last_s) begin
            state_d = CPR_SEQ;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = CPR_CP;
            cnt_d   = ph_cnt_s + CNT_ONE;
          end
        end
        CPR_SEQ: begin
          keep_s = 1'b1;
          if (ph_cnt_s == ph_seq_last_s) begin
            last_s  = 1'b1;
            state_d = CPR_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = CPR_SEQ;
            cnt_d   = ph_cnt_s + CNT_ONE;
          end
        end
        CPR_IDLE: begin
          state_d = CPR_IDLE;
          cnt_d   = CNT_ZERO;
        end
        default: begin
          state_d = CPR_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM, counter, latched lengths and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CPR_IDLE;
      cnt_q      <= CNT_ZERO;
      cp_last_q  <= CNT_ZERO;
      seq_last_q <= CNT_ZERO;
      busy_q     <= 1'b0;
      sop_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cp_last_q  <= cp_last_d;
      seq_last_q <= seq_last_d;
      busy_q     <= (state_d != CPR_IDLE);
      sop_err_q  <= sop_err_d;
    end
  end

  // A kept word loads only into an empty or draining register; else it is lost.
  always_comb begin
    load_s = keep_s & (~m_valid_q | m_ready);
    ovf_d  = keep_s & ~load_s;
    if (load_s) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
      m_last_d  = last_s;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
    end else begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
    end
  end

  // Output register toward the FIFO write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {WIDTH{1'b0}};
      m_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign sop_err = sop_err_q;

endmodule
